// File: rtl/decoder_seq_pkg.sv
// Shared encodings for the decoder_seq slice: the mode field that selects
// how the index evolves while running, and the two-state run FSM.
package decoder_seq_pkg;

  localparam int unsigned MODE_W = 2;

  // Run-time mode select, matches the two-bit mode input.
  typedef enum logic [MODE_W-1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  // Sequencer FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage : decoder_seq_pkg

// File: rtl/decoder_nx.sv
// Purely combinational index to one-hot decoder, IN_W-bit select in,
// 2**IN_W-bit one-hot out. The caller registers the result.
module decoder_nx #(
  parameter int unsigned IN_W = 3,
  localparam int unsigned OUT_W = 2**IN_W
) (
  input  logic [IN_W-1:0]  sel_i,
  output logic [OUT_W-1:0] onehot_o
);

  // One bit per output line, set only where the line number equals the select.
  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      onehot_o[i] = (sel_i == IN_W'(i));
    end
  end

endmodule : decoder_nx

// File: rtl/decoder_seq.sv
// Registered one-hot decoder sequencer. An IDLE/RUN FSM gates the decode;
// while running, the index is loaded directly, scanned up or down modulo
// 2**IN_W with a wrap pulse on boundary crossing, or held.
// Optional build macro: DECODER_SEQ_STRIDE_EN adds a 'stride' input that
// replaces the fixed scan step of 1; carry/borrow of the step drives wrap.
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int unsigned IN_W = 3,
  localparam int unsigned OUT_W = 2**IN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [IN_W-1:0]   inp,
`ifdef DECODER_SEQ_STRIDE_EN
  input  logic [IN_W-1:0]   stride,
`endif
  output logic [OUT_W-1:0]  op,
  output logic [IN_W-1:0]   idx,
  output logic              active,
  output logic              wrap
);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    idx_q, idx_d;
  logic [OUT_W-1:0]   op_q, op_d;
  logic               active_q, active_d;
  logic               wrap_q, wrap_d;

  mode_e              mode_s;
  logic [IN_W-1:0]    step_s;
  logic [IN_W:0]      up_sum_s;
  logic [IN_W:0]      dn_diff_s;
  logic [OUT_W-1:0]   dec_s;

  assign mode_s = mode_e'(mode);

`ifdef DECODER_SEQ_STRIDE_EN
  assign step_s = stride;
`else
  assign step_s = IN_W'(1);
`endif

  // Scan arithmetic one bit wider than the index: the extra MSB is the
  // carry (up) or borrow (down), i.e. exactly the wrap condition. A zero
  // step yields an unchanged index and no carry, so it behaves as HOLD.
  always_comb begin
    up_sum_s  = {1'b0, idx_q} + {1'b0, step_s};
    dn_diff_s = {1'b0, idx_q} - {1'b0, step_s};
  end

  // Next-state, next-index and wrap selection for the IDLE/RUN FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
          if (mode_s == MODE_DIRECT && load) begin
            idx_d = inp;
          end
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          unique case (mode_s)
            MODE_DIRECT: begin
              if (load) begin
                idx_d = inp;
              end
            end
            MODE_SCAN_UP: begin
              idx_d  = up_sum_s[IN_W-1:0];
              wrap_d = up_sum_s[IN_W];
            end
            MODE_SCAN_DOWN: begin
              idx_d  = dn_diff_s[IN_W-1:0];
              wrap_d = dn_diff_s[IN_W];
            end
            MODE_HOLD: begin
              idx_d = idx_q;
            end
            default: begin
              idx_d = idx_q;
            end
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decode the next index so op lands in the same cycle as idx.
  decoder_nx #(
    .IN_W(IN_W)
  ) u_decoder_nx (
    .sel_i    (idx_d),
    .onehot_o (dec_s)
  );

  // Output gating: one-hot only when the next state is RUN, else all-zero.
  always_comb begin
    active_d = (state_d == ST_RUN);
    op_d     = active_d ? dec_s : '0;
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      active_q <= active_d;
      wrap_q   <= wrap_d;
    end
  end

  assign op     = op_q;
  assign idx    = idx_q;
  assign active = active_q;
  assign wrap   = wrap_q;

endmodule : decoder_seq

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq (IN_W=3) with an arithmetic reference
// model checked every cycle plus literal expectations at key points.
module tb_decoder_seq;

  localparam int IN_W  = 3;
  localparam int OUT_W = 8;

  logic             clk;
  logic             reset;
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [IN_W-1:0]  inp;
`ifdef DECODER_SEQ_STRIDE_EN
  logic [IN_W-1:0]  stride;
`endif
  logic [OUT_W-1:0] op;
  logic [IN_W-1:0]  idx;
  logic             active;
  logic             wrap;

  int n_cmp = 0;
  int n_bad = 0;

  decoder_seq #(.IN_W(IN_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .load   (load),
    .inp    (inp),
`ifdef DECODER_SEQ_STRIDE_EN
    .stride (stride),
`endif
    .op     (op),
    .idx    (idx),
    .active (active),
    .wrap   (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers, modular arithmetic.
  int m_idx;
  bit m_run;
  bit m_wrap;

  always @(posedge clk or posedge reset) begin
    int n, st;
    if (reset) begin
      m_idx = 0; m_run = 0; m_wrap = 0;
    end else begin
`ifdef DECODER_SEQ_STRIDE_EN
      st = int'(stride);
`else
      st = 1;
`endif
      m_wrap = 0;
      if (!m_run) begin
        if (en) begin
          m_run = 1;
          if (mode == 2'd0 && load) m_idx = int'(inp);
        end
      end else if (!en) begin
        m_run = 0;
      end else begin
        case (mode)
          2'd0: if (load) m_idx = int'(inp);
          2'd1: begin
            n = m_idx + st;
            m_wrap = (n >= OUT_W);
            m_idx = n % OUT_W;
          end
          2'd2: begin
            n = m_idx - st;
            m_wrap = (n < 0);
            m_idx = (n + OUT_W) % OUT_W;
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("op",     int'(op),     m_run ? (1 << m_idx) : 0);
    check("idx",    int'(idx),    m_idx);
    check("active", int'(active), int'(m_run));
    check("wrap",   int'(wrap),   int'(m_wrap));
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'd0; load = 1'b0; inp = '0;
`ifdef DECODER_SEQ_STRIDE_EN
    stride = 3'd1;
`endif
    #2;
    check("rst_op", int'(op), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_active", int'(active), 0);
    check("rst_wrap", int'(wrap), 0);
    tick();
    reset = 1'b0;
    tick();

    // Enter RUN with a direct load of 6.
    en = 1; mode = 2'd0; load = 1; inp = 3'd6;
    tick();
    check("ld6_active", int'(active), 1);
    check("ld6_idx", int'(idx), 6);
    check("ld6_op", int'(op), 8'b0100_0000);
    check("ld6_wrap", int'(wrap), 0);
    load = 0;

    // Scan up across the top boundary.
    mode = 2'd1;
    tick();
    check("up_idx7", int'(idx), 7);
    check("up_wrap7", int'(wrap), 0);
    tick();
    check("up_idx0", int'(idx), 0);
    check("up_op0", int'(op), 8'b0000_0001);
    check("up_wrap0", int'(wrap), 1);

    // Scan down across the bottom boundary, no idle cycle on mode change.
    mode = 2'd2;
    tick();
    check("dn_idx7", int'(idx), 7);
    check("dn_op7", int'(op), 8'b1000_0000);
    check("dn_wrap7", int'(wrap), 1);
    tick();
    check("dn_idx6", int'(idx), 6);
    check("dn_wrap6", int'(wrap), 0);

    // HOLD, then DIRECT with load low.
    mode = 2'd3; ticks(3);
    check("hold_idx", int'(idx), 6);
    mode = 2'd0; inp = 3'd2; ticks(2);
    check("noload_idx", int'(idx), 6);

    // Load 4, drop en, re-enter scanning up.
    load = 1; inp = 3'd4; tick(); load = 0;
    en = 0; tick();
    check("off_op", int'(op), 0);
    check("off_active", int'(active), 0);
    check("off_idx", int'(idx), 4);
    ticks(2);
    en = 1; mode = 2'd1; tick();
    check("reen_op", int'(op), 8'b0001_0000);
    check("reen_wrap", int'(wrap), 0);
    tick();
    check("reen_idx5", int'(idx), 5);

    // Asynchronous reset mid-scan, between edges.
    reset = 1;
    #1;
    check("async_op", int'(op), 0);
    check("async_idx", int'(idx), 0);
    check("async_active", int'(active), 0);
    check("async_wrap", int'(wrap), 0);
    #1 reset = 0;
    tick();
    check("post_rst_op", int'(op), 8'b0000_0001);
    check("post_rst_wrap", int'(wrap), 0);

    // Long scans both ways, including boundary pulses.
    ticks(10);
    mode = 2'd2; ticks(10);
    // IDLE entry with a direct load straight from IDLE, in down-scan after.
    en = 0; tick();
    mode = 2'd0; load = 1; inp = 3'd0; en = 1; tick(); load = 0;
    check("idle_ld0_op", int'(op), 8'b0000_0001);
    mode = 2'd2; tick();
    check("idle_ld0_wrap", int'(wrap), 1);

`ifdef DECODER_SEQ_STRIDE_EN
    mode = 2'd0; load = 1; inp = 3'd6; tick(); load = 0;
    stride = 3'd3; mode = 2'd1; tick();
    check("str3_idx", int'(idx), 1);
    check("str3_wrap", int'(wrap), 1);
    stride = 3'd0; tick();
    check("str0_idx", int'(idx), 1);
    check("str0_wrap", int'(wrap), 0);
    stride = 3'd5; mode = 2'd2; ticks(6);
    stride = 3'd1;
`endif

    en = 0; ticks(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_decoder_seq

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 The module SHALL have parameter IN_W, default 3, meaning the select index width.
REQ-002 The module SHALL have localparam OUT_W, equal to 2**IN_W, meaning the decoded output width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port en, input, 1 bit: run enable.
REQ-006 The module SHALL have port mode, input, 2 bits: 00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
REQ-007 The module SHALL have port load, input, 1 bit: capture inp (DIRECT mode only).
REQ-008 The module SHALL have port inp, input, IN_W bits: direct select index.
REQ-009 The module SHALL have port op, output, OUT_W bits: registered one-hot decode of idx, or all-zero when inactive.
REQ-010 The module SHALL have port idx, output, IN_W bits: current registered index.
REQ-011 The module SHALL have port active, output, 1 bit: high while the FSM is in RUN.
REQ-012 The module SHALL have port wrap, output, 1 bit: one-cycle pulse when a scan step crosses the index boundary.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and RUN, and every output SHALL be registered.
REQ-014 In IDLE with en=0, op SHALL be 0, active 0, wrap 0, and idx SHALL hold.
REQ-015 IDLE with en=1 SHALL go to RUN on the next edge and set active=1; op SHALL be one-hot(idx') on that same edge, with no scan step.
- idx' = inp if mode=DIRECT and load=1.
- idx' = idx otherwise.
REQ-016 RUN with en=0 SHALL go to IDLE on the next edge, with op=0, active=0 and idx retained.
REQ-017 In RUN/DIRECT, load=1 SHALL set idx<=inp and op<=1<<inp on the next edge; load=0 SHALL hold.
REQ-018 In RUN/SCAN_UP, each edge SHALL step idx by +1 modulo OUT_W, and op SHALL follow idx with the same latency.
REQ-019 SCAN_UP wrap SHALL pulse in the same cycle idx becomes 0 from OUT_W-1.
REQ-020 In RUN/SCAN_DOWN, each edge SHALL step idx by -1 modulo OUT_W.
REQ-021 SCAN_DOWN wrap SHALL pulse in the same cycle idx becomes OUT_W-1 from 0.
REQ-022 In RUN/HOLD, idx and op SHALL be unchanged and wrap SHALL be 0.
REQ-023 A mode change in RUN SHALL take effect at the next edge, starting from the current idx; there SHALL be no idle cycle.
REQ-024 wrap SHALL be 0 in every cycle that does not contain a boundary crossing, including IDLE/RUN transitions.
REQ-025 The module SHALL guarantee op is exactly one-hot in RUN and all-zero in IDLE, with no multi-hot glitch cycle.
REQ-026 When IN_W=1, scan SHALL alternate 0,1, and wrap SHALL pulse on every return to the boundary value.

Reset
REQ-027 reset=1 SHALL immediately force state=IDLE, idx=0, op=0, active=0 and wrap=0, independent of clk.
REQ-028 Reset asserted mid-scan SHALL abandon the scan, and no wrap pulse SHALL be generated.
REQ-029 After reset release, the first RUN entry SHALL follow REQ-015.

Configuration
REQ-030 When macro DECODER_SEQ_STRIDE_EN is defined, the module SHALL have port stride, input, IN_W bits, and scan steps SHALL be ±stride modulo OUT_W.
REQ-031 With DECODER_SEQ_STRIDE_EN defined, wrap SHALL pulse on carry out (SCAN_UP) or borrow (SCAN_DOWN).
REQ-032 With DECODER_SEQ_STRIDE_EN defined, stride=0 SHALL behave as HOLD, with no wrap.
REQ-033 Without DECODER_SEQ_STRIDE_EN, the stride port SHALL be absent and the step SHALL be fixed at 1.

Structure
REQ-034 Package decoder_seq_pkg SHALL hold the mode encodings (MODE_DIRECT, MODE_SCAN_UP, MODE_SCAN_DOWN, MODE_HOLD) and the FSM state encodings (ST_IDLE, ST_RUN).
REQ-035 Combinational decode SHALL be the sub-module decoder_nx, parametrised by IN_W, mapping index to one-hot; decoder_seq SHALL register its output.

Verification (IN_W=3)
REQ-036 The bench SHALL check: en=1, mode=00, load=1, inp=6 from IDLE -> next edge: active=1, idx=6, op=8'b0100_0000, wrap=0.
REQ-037 The bench SHALL check: from idx=6, mode=01 for 2 edges -> idx 7 then 0, op=8'b0000_0001, wrap=1 only in the idx=0 cycle.
REQ-038 The bench SHALL check: from idx=0, mode=10 for 1 edge -> idx=7, op=8'b1000_0000, wrap=1; the next edge gives idx=6, wrap=0.
REQ-039 The bench SHALL check: en=0 at idx=4 -> next edge: op=0, active=0, idx=4; en=1 with mode=01 -> op=8'b0001_0000, then idx=5.
REQ-040 The bench SHALL check: reset pulsed between edges at idx=5 in SCAN_UP -> op=0, idx=0, active=0 before the next edge; no wrap.
REQ-041 The bench SHALL check, with DECODER_SEQ_STRIDE_EN: stride=3, idx=6, mode=01 -> idx=1, wrap=1; stride=0 -> idx holds, wrap=0.
